// File: rtl/uart_rx_mini_if.sv
// APB slave bus bundle for uart_rx_mini.
// The master drives the request side; the slave returns read data, ready and error.
interface uart_rx_mini_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/uart_rx_mini.sv
// 8N1 UART receiver: oversampled deframer, small receive FIFO, APB register view.
// Optional feature macro UART_RX_RTS_EN: drives active-low rts from the FIFO level.
module uart_rx_mini #(
    parameter int unsigned CLK_DIV    = 100,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_mini_if.slave  apbs,
    input  logic           rx,
    output logic           rts,
    output logic           irq,
    output logic           dreq
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = AW + 1;

    localparam logic [15:0]   DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0]   HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta_q;
    logic          rx_s_q;
    logic          rx_prev_q;

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          ovr_q;
    logic          frame_q;

    logic [15:0]   tick_at;
    logic          bit_tick;
    logic          push;
    logic          frame_ev;

    logic          rd_acc;
    logic          wr_acc;
    logic          sel_data;
    logic          sel_stat;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovr_ev;
    logic          clr_ovr;
    logic          clr_frame;
    logic [7:0]    lvl_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // START samples at half a bit period, all later bits one full period apart.
    assign tick_at  = (state_q == S_START) ? HALF_M1 : DIV_M1;
    assign bit_tick = (cnt_q == tick_at);
    assign push     = (state_q == S_STOP) && bit_tick && rx_s_q;
    assign frame_ev = (state_q == S_STOP) && bit_tick && !rx_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_s_q) begin
                        state_q   <= S_START;
                        bit_cnt_q <= '0;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        cnt_q   <= '0;
                        state_q <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        cnt_q   <= '0;
                        state_q <= rx_s_q ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rd_acc    = apbs.psel && apbs.penable && !apbs.pwrite;
    assign wr_acc    = apbs.psel && apbs.penable && apbs.pwrite;
    assign sel_data  = (apbs.paddr[3:2] == 2'd0);
    assign sel_stat  = (apbs.paddr[3:2] == 2'd1);
    assign empty     = (level_q == '0);
    assign full      = (level_q == DEPTH_L);
    assign pop       = rd_acc && sel_data && !empty;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
    assign push_ok   = push && (!full || pop);
    assign ovr_ev    = push && full && !pop;
    assign clr_ovr   = wr_acc && sel_stat && apbs.pwdata[1];
    assign clr_frame = wr_acc && sel_stat && apbs.pwdata[2];

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            ovr_q   <= ovr_ev   || (ovr_q   && !clr_ovr);
            frame_q <= frame_ev || (frame_q && !clr_frame);
        end
    end

    assign lvl_ext = 8'(level_q);

    always_comb begin
        apbs.prdata = '0;
        if (apbs.psel && !apbs.pwrite) begin
            if (sel_data) begin
                apbs.prdata = empty ? 32'h8000_0000 : {24'h0, mem_q[rd_ptr_q]};
            end else if (sel_stat) begin
                apbs.prdata = {24'h0, lvl_ext[3:0], 1'b0, frame_q, ovr_q, !empty};
            end
        end
    end

    assign apbs.pready  = 1'b1;
    assign apbs.pslverr = apbs.psel && apbs.penable && apbs.paddr[3];

    assign dreq = !empty;
    assign irq  = !empty || ovr_q || frame_q;

`ifdef UART_RX_RTS_EN
    logic rts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_q <= 1'b0;
        end else begin
            rts_q <= (level_q >= LW'(FIFO_DEPTH - 1));
        end
    end

    assign rts = rts_q;
`else
    assign rts = 1'b1;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, apbs.paddr[15:4], apbs.paddr[1:0],
                         apbs.pwdata[31:3], apbs.pwdata[0], lvl_ext[7:4]};

endmodule

// File: tb/tb_uart_rx_mini.sv
// Self-checking bench for uart_rx_mini: serial frames on rx, APB reads checked against a byte scoreboard.
module tb_uart_rx_mini;

    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned DEPTH   = 4;

`ifdef UART_RX_RTS_EN
    localparam logic RTS_EN = 1'b1;
`else
    localparam logic RTS_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic rts;
    logic irq;
    logic dreq;

    uart_rx_mini_if apbs();

    uart_rx_mini #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .apbs  (apbs),
        .rx    (rx),
        .rts   (rts),
        .irq   (irq),
        .dreq  (dreq)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] d;
    logic [31:0] e;
    logic        err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int stop_len, input bit expect_push);
        if (expect_push) exp_q.push_back(b);
        rx = 1'b0;
        repeat (CLK_DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) tick();
        end
        rx = stop_v;
        repeat (stop_len) tick();
        rx = 1'b1;
        repeat (4) tick();
    endtask

    function automatic logic [31:0] sb_next();
        if (exp_q.size() == 0) return 32'h8000_0000;
        return {24'h0, exp_q.pop_front()};
    endfunction

    task automatic apb_read(input logic [15:0] a, output logic [31:0] data, output logic slverr);
        apbs.psel    = 1'b1;
        apbs.penable = 1'b0;
        apbs.pwrite  = 1'b0;
        apbs.paddr   = a;
        tick();
        apbs.penable = 1'b1;
        @(negedge clk);
        data   = apbs.prdata;
        slverr = apbs.pslverr;
        tick();
        apbs.psel    = 1'b0;
        apbs.penable = 1'b0;
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] data);
        apbs.psel    = 1'b1;
        apbs.penable = 1'b0;
        apbs.pwrite  = 1'b1;
        apbs.paddr   = a;
        apbs.pwdata  = data;
        tick();
        apbs.penable = 1'b1;
        tick();
        apbs.psel    = 1'b0;
        apbs.penable = 1'b0;
        apbs.pwrite  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({irq, dreq, rts, apbs.pslverr, apbs.pready} !== {2'b00, !RTS_EN, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs: got irq/dreq/rts/slverr/ready=%b required %b",
                     {irq, dreq, rts, apbs.pslverr, apbs.pready}, {2'b00, !RTS_EN, 1'b0, 1'b1});
        end
        checks++;
        if (apbs.prdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_prdata: got %h required 00000000", apbs.prdata);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        apb_read(16'h4, d, err);
        checks++;
        if (d !== 32'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_stat: got %h err=%b required 00000000 err=0", d, err);
        end
        apb_read(16'h0, d, err);
        checks++;
        if (d !== 32'h8000_0000) begin
            failures++;
            $display("FAIL reset_rxdata: got %h required 80000000", d);
        end
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1, CLK_DIV, 1'b1);
        apb_read(16'h4, d, err);
        checks++;
        if (d !== 32'h11) begin
            failures++;
            $display("FAIL basic_stat: got %h required 00000011", d);
        end
        @(negedge clk);
        checks++;
        if ({irq, dreq} !== 2'b11) begin
            failures++;
            $display("FAIL basic_irq_dreq: got %b required 11", {irq, dreq});
        end
        apb_read(16'h0, d, err);
        e = sb_next();
        checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL basic_rxdata: got %h required %h", d, e);
        end
        apb_read(16'h4, d, err);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL basic_stat_after: got %h required 00000000", d);
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (6) tick();
        rx = 1'b1;
        repeat (CLK_DIV * 2) tick();
        apb_read(16'h4, d, err);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL glitch_stat: got %h irq=%b required 00000000 irq=0", d, irq);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'hA3, 1'b0, 40, 1'b0);
        apb_read(16'h4, d, err);
        checks++;
        if (d !== 32'h4 || irq !== 1'b1 || dreq !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_stat: got %h irq=%b dreq=%b required 00000004 irq=1 dreq=0",
                     d, irq, dreq);
        end
        apb_write(16'h4, 32'h4);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_clear_irq: got %b required 0", irq);
        end
        apb_read(16'h8, d, err);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL slverr_0x8: got %b required 1", err);
        end
        apb_read(16'hC, d, err);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL slverr_0xC: got %b required 1", err);
        end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, CLK_DIV, exp_q.size() < DEPTH);
        end
        apb_read(16'h4, d, err);
        checks++;
        if (d !== 32'h43) begin
            failures++;
            $display("FAIL overrun_stat: got %h required 00000043", d);
        end
        checks++;
        if (rts !== 1'b1) begin
            failures++;
            $display("FAIL overrun_rts: got %b required 1", rts);
        end
        for (int i = 0; i < 5; i++) begin
            apb_read(16'h0, d, err);
            e = sb_next();
            checks++;
            if (d !== e) begin
                failures++;
                $display("FAIL overrun_read%0d: got %h required %h", i, d, e);
            end
        end
        apb_write(16'h4, 32'h2);
        apb_read(16'h4, d, err);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL overrun_clear: got %h required 00000000", d);
        end
    endtask

    task automatic test_push_pop();
        send_frame(8'h11, 1'b1, CLK_DIV, 1'b1);
        send_frame(8'h22, 1'b1, CLK_DIV, 1'b1);
        send_frame(8'h33, 1'b1, CLK_DIV, 1'b1);
        send_frame(8'h44, 1'b1, CLK_DIV, 1'b1);
        // The read's closing edge lands on the stop-bit sample of the 0x77 frame.
        fork
            send_frame(8'h77, 1'b1, CLK_DIV, 1'b1);
            begin
                repeat (153) tick();
                apb_read(16'h0, d, err);
                e = sb_next();
                checks++;
                if (d !== e) begin
                    failures++;
                    $display("FAIL pushpop_pop: got %h required %h", d, e);
                end
            end
        join
        apb_read(16'h4, d, err);
        checks++;
        if (d !== 32'h41) begin
            failures++;
            $display("FAIL pushpop_stat: got %h required 00000041", d);
        end
        for (int i = 0; i < 5; i++) begin
            apb_read(16'h0, d, err);
            e = sb_next();
            checks++;
            if (d !== e) begin
                failures++;
                $display("FAIL pushpop_drain%0d: got %h required %h", i, d, e);
            end
        end
    endtask

    task automatic test_rts();
        for (int i = 0; i < 3; i++) begin
            send_frame(8'hB0 + 8'(i), 1'b1, CLK_DIV, 1'b1);
        end
        @(negedge clk);
        checks++;
        if (rts !== 1'b1) begin
            failures++;
            $display("FAIL rts_three: got %b required 1", rts);
        end
        apb_read(16'h0, d, err);
        e = sb_next();
        checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL rts_read: got %h required %h", d, e);
        end
        @(negedge clk);
        checks++;
        if (rts !== 1'b1) begin
            failures++;
            $display("FAIL rts_hold: got %b required 1", rts);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rts !== !RTS_EN) begin
            failures++;
            $display("FAIL rts_release: got %b required %b", rts, !RTS_EN);
        end
        for (int i = 0; i < 2; i++) begin
            apb_read(16'h0, d, err);
            e = sb_next();
            checks++;
            if (d !== e) begin
                failures++;
                $display("FAIL rts_drain%0d: got %h required %h", i, d, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        send_frame(8'h5A, 1'b1, CLK_DIV, 1'b1);
        b = 8'h9A;
        rx = 1'b0;
        repeat (CLK_DIV) tick();
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CLK_DIV) tick();
        end
        rx = b[3];
        repeat (CLK_DIV / 2) tick();
        rst_n = 1'b0;
        rx    = 1'b1;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (CLK_DIV * 2) tick();
        apb_read(16'h4, d, err);
        checks++;
        if (d !== 32'h0 || dreq !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stat: got %h dreq=%b required 00000000 dreq=0", d, dreq);
        end
        send_frame(8'hC4, 1'b1, CLK_DIV, 1'b1);
        for (int i = 0; i < 2; i++) begin
            apb_read(16'h0, d, err);
            e = sb_next();
            checks++;
            if (d !== e) begin
                failures++;
                $display("FAIL reset_mid_rx%0d: got %h required %h", i, d, e);
            end
        end
    endtask

    initial begin
        apbs.psel    = 1'b0;
        apbs.penable = 1'b0;
        apbs.pwrite  = 1'b0;
        apbs.paddr   = '0;
        apbs.pwdata  = '0;
        repeat (3) tick();
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_push_pop();
        test_rts();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
